// File: rtl/ct_biu_csr_pkg.sv
// Shared types and field positions for the BIU CSR access path.
package ct_biu_csr_pkg;

  typedef enum logic [1:0] {
    CSR_IDLE  = 2'd0,
    CSR_BEAT0 = 2'd1,
    CSR_BEAT1 = 2'd2,
    CSR_DONE  = 2'd3
  } csr_state_e;

  localparam int CSR_OP_W     = 16;
  localparam int CSR_OP_WR    = 15;
  localparam int CSR_OP_WIDE  = 14;
  localparam int CSR_IDX_MSB  = 11;
  localparam int CSR_IDX_LSB  = 0;
  localparam int CSR_IDX_W    = CSR_IDX_MSB - CSR_IDX_LSB + 1;
  localparam int CSR_DATA_W   = 64;
  localparam int CSR_TO_W     = 8;

  typedef struct packed {
    logic                 wr;
    logic                 wide;
    logic [CSR_IDX_W-1:0] idx;
  } csr_op_t;

  // The wide flag only means something on reads; writes are always one beat.
  function automatic csr_op_t csr_decode_op(input logic [CSR_OP_W-1:0] op);
    csr_op_t d;
    d.wr   = op[CSR_OP_WR];
    d.wide = op[CSR_OP_WIDE] & ~op[CSR_OP_WR];
    d.idx  = op[CSR_IDX_MSB:CSR_IDX_LSB];
    return d;
  endfunction

endpackage

// File: rtl/ct_biu_csr_wdog.sv
// Per-beat no-ack watchdog: counts enabled cycles and flags the last allowed one.
module ct_biu_csr_wdog
  import ct_biu_csr_pkg::*;
#(
  parameter int TIMEOUT_CYC = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [CSR_TO_W-1:0] TO_LAST = CSR_TO_W'(TIMEOUT_CYC - 1);

  logic [CSR_TO_W-1:0] cnt_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= '0;
    end else if (clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign expire = en && (cnt_reg == TO_LAST);

endmodule

// File: rtl/ct_biu_csr_access_ctrl.sv
// Executes one arbitrated CSR access as one or two req/ack beats toward L2C.
module ct_biu_csr_access_ctrl
  import ct_biu_csr_pkg::*;
#(
  parameter int TIMEOUT_CYC = 256
) (
  input  logic                  forever_cpuclk,
  input  logic                  cpurst_b,
  input  logic                  biu_csr_sel,
  input  logic [CSR_OP_W-1:0]   biu_csr_op,
  input  logic [CSR_DATA_W-1:0] biu_csr_wdata,
  output logic                  biu_csr_cmplt,
  output logic [127:0]          biu_csr_rdata,
  output logic                  biu_l2c_csr_req,
  output logic                  biu_l2c_csr_wen,
  output logic [CSR_IDX_W-1:0]  biu_l2c_csr_idx,
  output logic [CSR_DATA_W-1:0] biu_l2c_csr_wdata,
  input  logic                  l2c_biu_csr_ack,
  input  logic [CSR_DATA_W-1:0] l2c_biu_csr_rdata
);

  csr_state_e            state_reg;
  csr_op_t               op_reg;
  logic                  req_reg;
  logic                  cmplt_reg;
  logic                  wen_reg;
  logic [CSR_IDX_W-1:0]  idx_reg;
  logic [CSR_DATA_W-1:0] wdata_reg;
  logic [127:0]          rdata_reg;

  logic in_beat;
  logic wdog_clr;
  logic wdog_expire;

  assign in_beat  = (state_reg == CSR_BEAT0) || (state_reg == CSR_BEAT1);
  assign wdog_clr = !in_beat || l2c_biu_csr_ack;

  ct_biu_csr_wdog #(
    .TIMEOUT_CYC (TIMEOUT_CYC)
  ) u_wdog (
    .clk    (forever_cpuclk),
    .rst_n  (cpurst_b),
    .clr    (wdog_clr),
    .en     (in_beat),
    .expire (wdog_expire)
  );

  always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
    if (!cpurst_b) begin
      state_reg <= CSR_IDLE;
      op_reg    <= '0;
      req_reg   <= 1'b0;
      cmplt_reg <= 1'b0;
      wen_reg   <= 1'b0;
      idx_reg   <= '0;
      wdata_reg <= '0;
      rdata_reg <= '0;
    end else begin
      cmplt_reg <= 1'b0;
      case (state_reg)
        CSR_IDLE: begin
          if (biu_csr_sel) begin
            // Everything the access needs is captured here; later input changes are ignored.
            op_reg    <= csr_decode_op(biu_csr_op);
            wen_reg   <= biu_csr_op[CSR_OP_WR];
            idx_reg   <= biu_csr_op[CSR_IDX_MSB:CSR_IDX_LSB];
            wdata_reg <= biu_csr_wdata;
            rdata_reg <= '0;
            req_reg   <= 1'b1;
            state_reg <= CSR_BEAT0;
          end
        end

        CSR_BEAT0: begin
          if (l2c_biu_csr_ack) begin
            if (!op_reg.wr) begin
              rdata_reg[63:0] <= l2c_biu_csr_rdata;
            end
            if (op_reg.wide) begin
              idx_reg   <= idx_reg + 1'b1;
              wen_reg   <= 1'b0;
              state_reg <= CSR_BEAT1;
            end else begin
              req_reg   <= 1'b0;
              cmplt_reg <= 1'b1;
              state_reg <= CSR_DONE;
            end
          end else if (wdog_expire) begin
            req_reg   <= 1'b0;
            cmplt_reg <= 1'b1;
            state_reg <= CSR_DONE;
          end
        end

        CSR_BEAT1: begin
          if (l2c_biu_csr_ack) begin
            rdata_reg[127:64] <= l2c_biu_csr_rdata;
            req_reg           <= 1'b0;
            cmplt_reg         <= 1'b1;
            state_reg         <= CSR_DONE;
          end else if (wdog_expire) begin
            req_reg   <= 1'b0;
            cmplt_reg <= 1'b1;
            state_reg <= CSR_DONE;
          end
        end

        CSR_DONE: begin
          // sel is deliberately not sampled here so the requester can drop it.
          state_reg <= CSR_IDLE;
        end

        default: begin
          req_reg   <= 1'b0;
          state_reg <= CSR_IDLE;
        end
      endcase
    end
  end

  assign biu_csr_cmplt     = cmplt_reg;
  assign biu_csr_rdata     = rdata_reg;
  assign biu_l2c_csr_req   = req_reg;
  assign biu_l2c_csr_wen   = wen_reg;
  assign biu_l2c_csr_idx   = idx_reg;
  assign biu_l2c_csr_wdata = wdata_reg;

endmodule
